// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and constants for the data_mem_pipe memory.
//   mem_state_t : controller state (CLEAR = clear engine owns the write port,
//                 READY = requests accepted)
//   LW_DEFAULT  : default lane width in bits
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam int LW_DEFAULT = 8;

endpackage : data_mem_pkg

// File: rtl/data_mem_core.sv
// data_mem_core: storage array with a lane-masked write port and a registered
// (one-cycle latency) read port.
//   clk      : clock, all state on rising edge
//   rst_n    : synchronous active-low reset (clears the read response only)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data, LANES lanes of LW bits
//   wr_mask  : per-lane write enable
//   rd_en    : read strobe; response appears on rd_valid/rd_data next cycle
//   rd_addr  : read address
//   rd_valid : one-cycle pulse per read
//   rd_data  : read data, held between reads
module data_mem_core
    import data_mem_pkg::*;
#(
    parameter int LW    = LW_DEFAULT,
    parameter int LANES = 1,
    parameter int A     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [A-1:0]        wr_addr,
    input  logic [LW*LANES-1:0] wr_data,
    input  logic [LANES-1:0]    wr_mask,
    input  logic                rd_en,
    input  logic [A-1:0]        rd_addr,
    output logic                rd_valid,
    output logic [LW*LANES-1:0] rd_data
);

    localparam int W     = LW * LANES;
    localparam int DEPTH = 2 ** A;

    logic [W-1:0] mem [DEPTH];

    logic         rd_valid_d, rd_valid_q;
    logic [W-1:0] rd_data_d,  rd_data_q;

    // Storage carries no reset; known contents come from the clear engine.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && wr_mask[i]) begin
                mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
            end
        end
    end

    // The array is sampled before this edge's write lands, so a write in
    // cycle N is visible to a read issued in cycle N+1.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule : data_mem_core

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: data memory with lane-masked writes, 1-cycle registered reads,
// a valid/ready request port and a hardware clear engine.
//   clk       : clock
//   Reset     : synchronous active-low reset
//   ReqValid  : request present
//   ReqReady  : request accepted this cycle when ReqValid is also high
//   ReqWrite  : 1 = write, 0 = read
//   ReqAddr   : entry address
//   ReqData   : write data
//   ReqMask   : per-lane write enable (ignored on reads)
//   ClearReq  : pulse, starts a runtime clear (ignored while clearing)
//   RespValid : one-cycle pulse carrying read data
//   RespData  : read data, holds last read value
//   Busy      : clear in progress
//   DbgState  : controller state, for observation only
//
// Handshake: a request transfers on every rising edge where ReqValid and
// ReqReady are both high. ReqReady depends only on the controller state, never
// on ReqValid, and stays high in READY so one request can transfer per cycle.
// Read responses cannot be back-pressured.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int LW      = LW_DEFAULT,
    parameter int LANES   = 1,
    parameter int A       = 8,
    parameter bit CLR_RST = 1'b1
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic                ReqWrite,
    input  logic [A-1:0]        ReqAddr,
    input  logic [LW*LANES-1:0] ReqData,
    input  logic [LANES-1:0]    ReqMask,
    input  logic                ClearReq,
    output logic                RespValid,
    output logic [LW*LANES-1:0] RespData,
    output logic                Busy,
    output mem_state_t          DbgState
);

    localparam int         W        = LW * LANES;
    localparam logic [A-1:0] CLR_LAST = {A{1'b1}};

    mem_state_t   state_d, state_q;
    logic [A-1:0] clr_ptr_d, clr_ptr_q;

    logic         accept;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic [LANES-1:0] wr_mask;
    logic         rd_en;

    assign Busy     = (state_q == CLEAR);
    assign ReqReady = (state_q == READY);
    assign DbgState = state_q;
    assign accept   = ReqValid && ReqReady;

    // Write port is owned by the clear engine while clearing, otherwise by
    // accepted write requests. Nothing is written while reset is held.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ReqAddr;
        wr_data = ReqData;
        wr_mask = ReqMask;
        rd_en   = 1'b0;
        if (Reset) begin
            if (state_q == CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = clr_ptr_q;
                wr_data = '0;
                wr_mask = {LANES{1'b1}};
            end else begin
                wr_en = accept && ReqWrite;
                rd_en = accept && !ReqWrite;
            end
        end
    end

    // A request accepted alongside ClearReq completes normally; the clear
    // starts on the following cycle from address 0.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + A'(1);
                if (clr_ptr_q == CLR_LAST) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (ClearReq) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = READY;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q   <= CLR_RST ? CLEAR : READY;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    data_mem_core #(
        .LW    (LW),
        .LANES (LANES),
        .A     (A)
    ) u_core (
        .clk      (clk),
        .rst_n    (Reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .rd_en    (rd_en),
        .rd_addr  (ReqAddr),
        .rd_valid (RespValid),
        .rd_data  (RespData)
    );

endmodule : data_mem_pipe

// File: tb/tb_data_mem_pipe.sv
module tb_data_mem_pipe;
  import data_mem_pkg::*;

  localparam int LW    = 8;
  localparam int LANES = 2;
  localparam int A     = 4;
  localparam int W     = LW * LANES;
  localparam int DEPTH = 16;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with clear after reset ----------------
  logic             rst_n;
  logic             req_valid, req_write, clear_req;
  logic [A-1:0]     req_addr;
  logic [W-1:0]     req_data;
  logic [LANES-1:0] req_mask;
  logic             req_ready, resp_valid, busy;
  logic [W-1:0]     resp_data;
  mem_state_t       dbg_state;

  data_mem_pipe #(.LW(LW), .LANES(LANES), .A(A), .CLR_RST(1'b1)) u_dut (
    .clk(clk), .Reset(rst_n), .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqWrite(req_write), .ReqAddr(req_addr), .ReqData(req_data),
    .ReqMask(req_mask), .ClearReq(clear_req), .RespValid(resp_valid),
    .RespData(resp_data), .Busy(busy), .DbgState(dbg_state)
  );

  // ---------------- DUT without clear after reset ----------------
  logic             rst2_n;
  logic             req2_valid, req2_write, clear2_req;
  logic [A-1:0]     req2_addr;
  logic [W-1:0]     req2_data;
  logic [LANES-1:0] req2_mask;
  logic             req2_ready, resp2_valid, busy2;
  logic [W-1:0]     resp2_data;
  mem_state_t       dbg2_state;

  data_mem_pipe #(.LW(LW), .LANES(LANES), .A(A), .CLR_RST(1'b0)) u_dut_nc (
    .clk(clk), .Reset(rst2_n), .ReqValid(req2_valid), .ReqReady(req2_ready),
    .ReqWrite(req2_write), .ReqAddr(req2_addr), .ReqData(req2_data),
    .ReqMask(req2_mask), .ClearReq(clear2_req), .RespValid(resp2_valid),
    .RespData(resp2_data), .Busy(busy2), .DbgState(dbg2_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int errors = 0;
  int checks = 0;

  logic [W-1:0] ref_mem [DEPTH];
  int           busy_left;      // cycles of clear still to run
  logic         ref_rv;
  logic [W-1:0] ref_rd;
  bit           state_known = 1'b0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus on the main DUT, with the model stepped in
  // parallel. The whole memory is zeroed in the model the moment a clear
  // starts; no read can be accepted until the clear has run its length.
  task automatic cycle(input bit rn, input bit valid, input bit write,
                       input logic [A-1:0] addr, input logic [W-1:0] data,
                       input logic [LANES-1:0] mask, input bit clr,
                       input string tag);
    bit accepted;
    rst_n     = rn;
    req_valid = valid;
    req_write = write;
    req_addr  = addr;
    req_data  = data;
    req_mask  = mask;
    clear_req = clr;
    #1;
    if (state_known) begin
      check_val({tag, ".busy"},  W'(busy),      W'(busy_left != 0));
      check_val({tag, ".ready"}, W'(req_ready), W'(busy_left == 0));
    end
    accepted = rn && valid && (busy_left == 0);
    @(posedge clk);
    #1;
    if (!rn) begin
      ref_rv    = 1'b0;
      ref_rd    = '0;
      busy_left = DEPTH;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else begin
      ref_rv = 1'b0;
      if (accepted && !write) begin
        ref_rv = 1'b1;
        ref_rd = ref_mem[addr];
      end
      if (accepted && write) begin
        for (int l = 0; l < LANES; l++)
          if (mask[l]) ref_mem[addr][l*LW +: LW] = data[l*LW +: LW];
      end
      if (busy_left > 0) begin
        busy_left--;
      end else if (clr) begin
        busy_left = DEPTH;
        foreach (ref_mem[i]) ref_mem[i] = '0;
      end
    end
    state_known = 1'b1;
    check_val({tag, ".rvalid"}, W'(resp_valid), W'(ref_rv));
    check_val({tag, ".rdata"},  resp_data,      ref_rd);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, '0, '0, '0, 0, tag);
  endtask

  task automatic rd(input logic [A-1:0] addr, input string tag);
    cycle(1, 1, 0, addr, 16'h0000, 2'b00, 0, tag);
  endtask

  task automatic wr(input logic [A-1:0] addr, input logic [W-1:0] data,
                    input logic [LANES-1:0] mask, input string tag);
    cycle(1, 1, 1, addr, data, mask, 0, tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_data = '0;
    req_mask = '0; clear_req = 0;
    rst2_n = 0; req2_valid = 0; req2_write = 0; req2_addr = '0; req2_data = '0;
    req2_mask = '0; clear2_req = 0;
    busy_left = DEPTH; ref_rv = 0; ref_rd = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    @(negedge clk);

    // reset, then the full power-on clear
    cycle(0, 0, 0, '0, '0, '0, 0, "reset0");
    cycle(0, 1, 0, '0, '0, '0, 0, "reset1");
    idle(DEPTH, "post_reset_clear");
    for (int a = 0; a < DEPTH; a++) rd(A'(a), "read_zero");
    idle(1, "drain");

    // full and partial lane writes
    wr(4'd5, 16'hABCD, 2'b11, "wr_full");
    rd(4'd5, "rd_full");
    idle(1, "rd_full_resp");
    check_val("abcd_value", resp_data, 16'hABCD);
    wr(4'd5, 16'h1234, 2'b01, "wr_lane0");
    rd(4'd5, "rd_lane0");
    idle(1, "rd_lane0_resp");
    check_val("ab34_value", resp_data, 16'hAB34);
    wr(4'd5, 16'hFFFF, 2'b00, "wr_nomask");
    rd(4'd5, "rd_nomask");

    // back-to-back reads then a gap
    wr(4'd1, 16'h1111, 2'b11, "wr1");
    wr(4'd2, 16'h2222, 2'b11, "wr2");
    wr(4'd3, 16'h3333, 2'b10, "wr3");
    rd(4'd1, "b2b_rd1");
    rd(4'd2, "b2b_rd2");
    rd(4'd3, "b2b_rd3");
    idle(2, "b2b_gap");

    // read together with a runtime clear; clear request during clear ignored
    cycle(1, 1, 0, 4'd5, '0, '0, 1, "rd_with_clear");
    check_val("rd_with_clear_data", resp_data, 16'hAB34);
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 1, 4'd5, 16'hBEEF, 2'b11, 1, "clear_run");
    rd(4'd5, "rd_after_clear");
    idle(1, "rd_after_clear_resp");
    check_val("after_clear_zero", resp_data, 16'h0000);

    // reset in the middle of a clear restarts it
    wr(4'd7, 16'h7777, 2'b11, "wr7");
    cycle(1, 0, 0, '0, '0, '0, 1, "start_clear");
    idle(7, "clear_part");
    cycle(0, 0, 0, '0, '0, '0, 0, "mid_clear_reset");
    idle(DEPTH, "restarted_clear");
    rd(4'd7, "rd7_after_restart");

    // reset cuts off a pending read response
    wr(4'd9, 16'h9999, 2'b11, "wr9");
    rd(4'd9, "rd9");
    cycle(0, 1, 0, 4'd9, '0, '0, 0, "reset_after_read");
    idle(DEPTH + 1, "clear_after_reset");

    // randomized traffic with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1), A'($urandom_range(0, DEPTH - 1)),
            W'($urandom), LANES'($urandom_range(0, 3)),
            ($urandom_range(0, 39) == 0), "random");
    end

    // build without power-on clear: ready immediately after release
    rst2_n = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("nc_busy",  W'(busy2),      16'h0000);
    check_val("nc_ready", W'(req2_ready), 16'h0001);
    req2_valid = 1; req2_write = 1; req2_addr = 4'd9; req2_data = 16'h5A5A; req2_mask = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    req2_write = 0;
    @(posedge clk); #1;
    @(negedge clk);
    req2_valid = 0;
    check_val("nc_rvalid", W'(resp2_valid), 16'h0001);
    check_val("nc_rdata",  resp2_data,      16'h5A5A);
    @(posedge clk); #1;
    check_val("nc_rvalid_low", W'(resp2_valid), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_data_mem_pipe
